// File: rtl/irq_ctrl.sv
// Interrupt controller: latches level/edge pending bits, masks them and runs a
// request/acknowledge/EOI handshake that presents one prioritised source to the CPU.
module irq_ctrl #(
  parameter int NSRC = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     ADDR,
  input  logic            IcWe,
  input  logic [31:0]     Din,
  output logic [31:0]     Dout,
  input  logic [NSRC-1:0] HWIrq,
  output logic            IntReq,
  input  logic            IntAck,
  output logic [1:0]      o_dbg_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_SERV = 2'd2;

  logic [NSRC-1:0] r_mask;
  logic [NSRC-1:0] r_mode;
  logic [NSRC-1:0] r_pend;
  logic [NSRC-1:0] r_irq_q;
  logic [NSRC-1:0] r_irq_p;
  logic [2:0]      r_id;
  logic            r_active;
  logic            r_int_req;
  logic [1:0]      r_state;

  logic [1:0]      w_sel;
  logic            w_wr_mask;
  logic            w_wr_mode;
  logic            w_wr_pend;
  logic            w_wr_vec;
  logic            w_eoi;
  logic [NSRC-1:0] w_cand;
  logic            w_any;
  logic [2:0]      w_winner;
  logic [NSRC-1:0] w_eoi_clr;
  logic [NSRC-1:0] w_w1c;
  logic [NSRC-1:0] w_edge_next;
  logic [NSRC-1:0] w_pend_mode;
  logic [NSRC-1:0] w_mode_chg;
  logic [NSRC-1:0] w_pend_next;
  logic            w_unused;

  assign w_sel     = ADDR[3:2];
  assign w_wr_mask = IcWe && (w_sel == 2'd0);
  assign w_wr_mode = IcWe && (w_sel == 2'd1);
  assign w_wr_pend = IcWe && (w_sel == 2'd2);
  assign w_wr_vec  = IcWe && (w_sel == 2'd3);
  assign w_eoi     = w_wr_vec && (r_state == ST_SERV);
  assign w_unused  = ^{ADDR[31:4], ADDR[1:0], Din[31:NSRC]};

  assign w_cand = r_pend & r_mask;
  assign w_any  = |w_cand;

  // Scanning downward leaves the lowest set index, i.e. the highest priority.
  always_comb begin
    w_winner = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (w_cand[i]) w_winner = i[2:0];
    end
  end

  always_comb begin
    w_eoi_clr = '0;
    for (int i = 0; i < NSRC; i++) begin
      w_eoi_clr[i] = w_eoi && (r_id == i[2:0]);
    end
  end

  // A fresh edge overrides a same-cycle W1C or EOI clear so no event is lost.
  assign w_w1c       = w_wr_pend ? Din[NSRC-1:0] : '0;
  assign w_edge_next = (r_irq_q & ~r_irq_p) | (r_pend & ~(w_w1c | w_eoi_clr));
  assign w_pend_mode = (r_mode & w_edge_next) | (~r_mode & r_irq_q);

  // Bits whose mode flips restart: edge bits cleared, level bits follow irq_q.
  assign w_mode_chg  = w_wr_mode ? (Din[NSRC-1:0] ^ r_mode) : '0;
  assign w_pend_next = (w_pend_mode & ~w_mode_chg)
                     | (w_mode_chg & ~Din[NSRC-1:0] & r_irq_q);

  always_comb begin
    Dout = '0;
    case (w_sel)
      2'd0: Dout[NSRC-1:0] = r_mask;
      2'd1: Dout[NSRC-1:0] = r_mode;
      2'd2: Dout[NSRC-1:0] = r_pend;
      default: begin
        Dout[31]  = r_active;
        Dout[2:0] = r_id;
      end
    endcase
  end

  // Handshake: IntReq is held high only in REQ; IntAck is a one-cycle pulse honoured
  // only while IntReq=1; EOI is any VEC write, honoured only while a source is in service.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mask    <= '0;
      r_mode    <= '0;
      r_pend    <= '0;
      r_irq_q   <= '0;
      r_irq_p   <= '0;
      r_id      <= '0;
      r_active  <= 1'b0;
      r_int_req <= 1'b0;
      r_state   <= ST_IDLE;
    end else begin
      r_irq_q <= HWIrq;
      r_irq_p <= r_irq_q;
      r_pend  <= w_pend_next;
      if (w_wr_mask) r_mask <= Din[NSRC-1:0];
      if (w_wr_mode) r_mode <= Din[NSRC-1:0];
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state   <= ST_REQ;
            r_int_req <= 1'b1;
          end
        end
        ST_REQ: begin
          if (IntAck) begin
            r_int_req <= 1'b0;
            if (w_any) begin
              r_id     <= w_winner;
              r_active <= 1'b1;
              r_state  <= ST_SERV;
            end else begin
              r_state <= ST_IDLE;
            end
          end else if (!w_any) begin
            r_int_req <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        ST_SERV: begin
          r_int_req <= 1'b0;
          if (w_wr_vec) begin
            r_active <= 1'b0;
            r_id     <= '0;
            r_state  <= ST_IDLE;
          end
        end
        default: begin
          r_int_req <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign IntReq      = r_int_req;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed walk through the interrupt scenarios, then random
// traffic compared every cycle against a behavioural model of the controller.
module tb_irq_ctrl;
  localparam int NSRC = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic            we;
  logic            ack;
  logic [31:0]     addr;
  logic [31:0]     din;
  logic [NSRC-1:0] hw;
  logic [31:0]     dout;
  logic            int_req;
  logic [1:0]      dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: REQ is "request outstanding", SERV is "a source is active".
  logic [NSRC-1:0] m_mask, m_mode, m_pend, m_q, m_p;
  logic [2:0]      m_id;
  logic            m_active, m_req;

  irq_ctrl #(.NSRC(NSRC)) dut (
    .clk(clk), .reset(rst), .ADDR(addr), .IcWe(we), .Din(din), .Dout(dout),
    .HWIrq(hw), .IntReq(int_req), .IntAck(ack), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] sel);
    case (sel)
      2'd0:    return 32'(m_mask);
      2'd1:    return 32'(m_mode);
      2'd2:    return 32'(m_pend);
      default: return {m_active, 28'b0, m_id};
    endcase
  endfunction

  task automatic model_step();
    logic [NSRC-1:0] cand, np;
    logic [1:0] sel;
    bit wr_mask, wr_mode, wr_pend, wr_vec, clr;
    int win;
    sel     = addr[3:2];
    wr_mask = we && (sel == 2'd0);
    wr_mode = we && (sel == 2'd1);
    wr_pend = we && (sel == 2'd2);
    wr_vec  = we && (sel == 2'd3);
    if (rst) begin
      m_mask = '0; m_mode = '0; m_pend = '0; m_q = '0; m_p = '0;
      m_id = '0; m_active = 1'b0; m_req = 1'b0;
      return;
    end
    cand = m_pend & m_mask;
    win = 0;
    while (win < NSRC && !cand[win]) win++;
    for (int i = 0; i < NSRC; i++) begin
      if (wr_mode && (din[i] != m_mode[i])) begin
        np[i] = din[i] ? 1'b0 : m_q[i];
      end else if (!m_mode[i]) begin
        np[i] = m_q[i];
      end else begin
        clr   = (wr_pend && din[i]) || (wr_vec && m_active && (m_id == i));
        np[i] = (m_q[i] && !m_p[i]) || (m_pend[i] && !clr);
      end
    end
    if (m_active) begin
      if (wr_vec) begin
        m_active = 1'b0;
        m_id     = '0;
      end
    end else if (m_req) begin
      if (ack) begin
        m_req = 1'b0;
        if (cand != 0) begin
          m_active = 1'b1;
          m_id     = 3'(win);
        end
      end else if (cand == 0) begin
        m_req = 1'b0;
      end
    end else if (cand != 0) begin
      m_req = 1'b1;
    end
    m_pend = np;
    if (wr_mask) m_mask = din[NSRC-1:0];
    if (wr_mode) m_mode = din[NSRC-1:0];
    m_p = m_q;
    m_q = hw;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check("intreq_vs_model", {31'b0, int_req}, {31'b0, m_req});
  endtask

  task automatic wr(input logic [1:0] sel, input logic [31:0] data);
    addr = {28'b0, sel, 2'b00};
    din  = data;
    we   = 1'b1;
    step();
    we   = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [1:0] sel, input logic [31:0] exp);
    addr = {28'b0, sel, 2'b00};
    #1;
    check(tag, dout, exp);
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; ack = 1'b0; addr = '0; din = '0; hw = '0;
    m_mask = '0; m_mode = '0; m_pend = '0; m_q = '0; m_p = '0;
    m_id = '0; m_active = 1'b0; m_req = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    rd("rst_mask", 2'd0, 32'h0);
    rd("rst_mode", 2'd1, 32'h0);
    rd("rst_pend", 2'd2, 32'h0);
    rd("rst_vec",  2'd3, 32'h0);
    check("rst_intreq", {31'b0, int_req}, 32'h0);

    // Edge mode, one-cycle pulse on source 0
    wr(2'd0, 32'h01);
    wr(2'd1, 32'h01);
    hw = 6'h01;
    step();
    hw = 6'h00;
    step();
    rd("edge0_pend", 2'd2, 32'h01);
    check("edge0_req_early", {31'b0, int_req}, 32'h0);
    step();
    check("edge0_req", {31'b0, int_req}, 32'h1);
    pulse_ack();
    check("edge0_req_after_ack", {31'b0, int_req}, 32'h0);
    rd("edge0_vec", 2'd3, 32'h8000_0000);
    wr(2'd3, 32'h0);
    rd("edge0_pend_eoi", 2'd2, 32'h0);
    rd("edge0_vec_eoi", 2'd3, 32'h0);

    // Level mode, two sources, priority then re-request after EOI
    wr(2'd1, 32'h00);
    wr(2'd0, 32'h3F);
    hw = 6'h24;
    step();
    step();
    check("lvl_req_early", {31'b0, int_req}, 32'h0);
    step();
    check("lvl_req", {31'b0, int_req}, 32'h1);
    pulse_ack();
    rd("lvl_vec_id2", 2'd3, 32'h8000_0002);
    hw = 6'h20;
    step();
    step();
    wr(2'd3, 32'h0);
    rd("lvl_vec_eoi", 2'd3, 32'h0);
    check("lvl_req_eoi", {31'b0, int_req}, 32'h0);
    step();
    check("lvl_rereq", {31'b0, int_req}, 32'h1);
    pulse_ack();
    rd("lvl_vec_id5", 2'd3, 32'h8000_0005);
    hw = 6'h00;
    step();
    step();
    wr(2'd3, 32'h0);
    step();
    check("lvl_idle", {31'b0, int_req}, 32'h0);

    // Level drops before acknowledge; late IntAck is ignored
    wr(2'd0, 32'h02);
    hw = 6'h02;
    step();
    step();
    step();
    check("drop_req", {31'b0, int_req}, 32'h1);
    hw = 6'h00;
    step();
    step();
    step();
    check("drop_req_gone", {31'b0, int_req}, 32'h0);
    pulse_ack();
    rd("drop_vec", 2'd3, 32'h0);
    check("drop_req_after_ack", {31'b0, int_req}, 32'h0);

    // Edge mode source 3: W1C loses to a same-cycle edge; MASK write uses old mask
    wr(2'd1, 32'h08);
    wr(2'd0, 32'h00);
    hw = 6'h08;
    step();
    hw = 6'h00;
    step();
    rd("e3_pend", 2'd2, 32'h08);
    hw = 6'h08;
    step();
    hw = 6'h00;
    wr(2'd2, 32'h08);
    rd("e3_set_wins", 2'd2, 32'h08);
    wr(2'd0, 32'h08);
    check("e3_old_mask", {31'b0, int_req}, 32'h0);
    step();
    check("e3_req", {31'b0, int_req}, 32'h1);
    pulse_ack();
    rd("e3_vec", 2'd3, 32'h8000_0003);
    wr(2'd3, 32'h0);
    rd("e3_pend_eoi", 2'd2, 32'h0);
    wr(2'd0, 32'h00);
    hw = 6'h08;
    step();
    hw = 6'h00;
    step();
    step();
    wr(2'd2, 32'h08);
    rd("e3_w1c_clears", 2'd2, 32'h0);

    // Reset while in service
    wr(2'd1, 32'h00);
    wr(2'd0, 32'h10);
    hw = 6'h10;
    step();
    step();
    step();
    check("rs_req", {31'b0, int_req}, 32'h1);
    pulse_ack();
    rd("rs_vec", 2'd3, 32'h8000_0004);
    rst = 1'b1;
    step();
    rst = 1'b0;
    rd("rs_vec_after", 2'd3, 32'h0);
    rd("rs_mask_after", 2'd0, 32'h0);
    check("rs_req_after", {31'b0, int_req}, 32'h0);
    for (int k = 0; k < 4; k++) step();
    check("rs_no_req_masked", {31'b0, int_req}, 32'h0);
    wr(2'd0, 32'h10);
    step();
    check("rs_req_remask", {31'b0, int_req}, 32'h1);
    pulse_ack();
    hw = 6'h00;
    step();
    step();
    wr(2'd3, 32'h0);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      int b;
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 3) == 0) begin
        b = $urandom_range(0, NSRC - 1);
        hw[b] = ~hw[b];
      end
      we   = ($urandom_range(0, 3) == 0);
      addr = {28'b0, 2'($urandom_range(0, 3)), 2'b00};
      din  = $urandom();
      ack  = ($urandom_range(0, 2) == 0);
      #1;
      check("dout_vs_model", dout, model_read(addr[3:2]));
      step();
    end
    rst = 1'b0; we = 1'b0; ack = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Memory-mapped interrupt controller that collects the device interrupt lines (timers, UART) and presents one prioritised request to the CPU. It latches per-source pending bits in level or edge mode and applies a mask. It tracks which source is in service through a request/acknowledge/end-of-interrupt handshake. It sits on the same system bus as the timer and UART peripherals, and is the consumer of their IRQ outputs.

## Interface
- NSRC, 6: number of interrupt sources (1..8); source 0 has highest priority.
- clk  in  1  system clock; everything updates on posedge.
- reset  in  1  synchronous, active-high; clears all state.
- ADDR  in  32  bus byte address; only ADDR[3:2] is decoded.
- IcWe  in  1  bus write enable for this block.
- Din  in  32  bus write data.
- Dout  out  32  read data for register ADDR[3:2], combinational.
- HWIrq  in  NSRC  raw device interrupt lines, active-high.
- IntReq  out  1  registered interrupt request to CPU.
- IntAck  in  1  one-cycle pulse from CPU: request taken.

## Operation
- Registers, by ADDR[3:2]; unused bits read 0:
  - 0 MASK[NSRC-1:0], R/W. A 1 enables the source.
  - 1 MODE[NSRC-1:0], R/W. 1 selects edge mode; 0 selects level mode.
  - 2 PEND[NSRC-1:0]. Read returns pending bits. Write-1-to-clear applies to edge-mode bits only; level-mode bits ignore writes.
  - 3 VEC. Read returns {active, 28'b0, id[2:0]} at bits 31 and 2:0. Any write is an EOI.
- Input path:
  - irq_q <= HWIrq every cycle; irq_p <= irq_q.
  - Level-mode pend[i] <= irq_q[i].
  - Edge-mode pend[i] is set when irq_q[i] & ~irq_p[i], and stays set until W1C or EOI for id i.
- Candidate set: cand = pend & MASK. Winner = lowest set index of cand.
- State machine, 2-bit, states IDLE, REQ, SERV:
  - IDLE: if cand != 0, go to REQ and set IntReq <= 1.
  - REQ, IntAck=1 with cand != 0: latch id <= winner and active <= 1, go to SERV, IntReq <= 0.
  - REQ, IntAck=1 with cand == 0 (spurious): go to IDLE, IntReq <= 0, active stays 0.
  - REQ, IntAck=0 with cand == 0 (level dropped, source masked or cleared): go to IDLE, IntReq <= 0.
  - SERV: IntReq held 0. An EOI write clears pend[id] if that source is edge mode, sets active <= 0, and goes to IDLE.
- Ignored events:
  - EOI in IDLE or REQ.
  - IntAck in IDLE or SERV.
- Write to MODE: changed bits take effect next cycle. A bit switched edge to level takes the level of irq_q. A bit switched level to edge starts cleared.

## Timing
- Reset values:
  - MASK, MODE, PEND, irq_q, irq_p, id, active: 0.
  - IntReq: 0. State: IDLE.
  - Dout then reads 0 at every address.
- Latency, with MASK set and state IDLE, HWIrq first sampled high at edge k:
  - Edge k+1: pend set.
  - Edge k+2: state REQ and IntReq=1.
- IntAck sampled at edge a: IntReq=0 and VEC valid after edge a.
- EOI at edge e: state IDLE after edge e. If another candidate exists, IntReq=1 after edge e+1.
- Same-cycle W1C and hardware edge set on one bit: the set wins, so no event is lost. The same rule applies to EOI against a new edge for id.
- A bus write to MASK in the same cycle the IDLE->REQ decision is made: the decision uses the old MASK.
- Reset asserted in any state, including SERV: all state returns to reset values at that edge, and the in-service id is discarded.

## Test plan
- Reset, then read all 4 addresses -> Dout=0 each; IntReq=0.
- MASK=0x01, MODE=0x01, 1-cycle pulse on HWIrq[0] -> PEND=0x01 one edge after sampling, IntReq=1 one edge later. IntAck pulse -> VEC=0x80000000, IntReq=0. EOI -> PEND=0, VEC=0.
- MASK=0x3F, level mode, HWIrq=0x24 held -> IntReq=1, IntAck -> VEC id=2. Drop HWIrq[2], EOI -> IntReq=1 again, IntAck -> id=5.
- Level mode, HWIrq[1] high then low before IntAck, MASK=0x02 -> IntReq returns to 0, state IDLE. A later IntAck is ignored and VEC stays 0.
- Edge mode bit 3: W1C write PEND=0x08 in the same cycle as a new edge on HWIrq[3] -> PEND[3] stays 1 and IntReq asserts.
- Reset asserted while in SERV with id=4 -> next cycle VEC=0, IntReq=0, MASK=0. HWIrq held high does not request until MASK is rewritten.
